// File: rtl/mips_pkg.sv
// mips_pkg: shared divider state encodings and control constants.
package mips_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic [31:0] ZeroWord             = 32'h0000_0000;

endpackage

// File: rtl/mips_div_if.sv
// mips_div_if: EX-stage request/result bundle between the pipeline and the divider.
interface mips_div_if #(parameter int WIDTH = 32);

    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic             annul_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             ready_o;
    logic             stallreq_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  hi_o, lo_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output hi_o, lo_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    // One extra bit so divisors above 2^(WIDTH-1) still compare correctly.
    logic [WIDTH:0] diff;

    assign diff  = {rem_i, bit_i} - {1'b0, divisor_i};
    assign q_o   = ~diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};

endmodule

// File: rtl/mips_div.sv
// mips_div: multi-cycle radix-2 restoring divider for DIV/DIVU with pipeline stall and annul.
module mips_div
    import mips_pkg::*;
#(parameter int WIDTH = 32)
(
    input logic       clk,
    input logic       rst,
    mips_div_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] step_rem, quo_fin, op1_abs, op2_abs;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // The negation of the most negative value wraps to itself, read back as unsigned 2^(WIDTH-1).
    assign op1_abs = (bus.signed_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = (bus.signed_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    assign quo_fin = {quo_q[WIDTH-2:0], step_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        rdy_d   = rdy_q;
        case (state_q)
            DIV_FREE: if (bus.start_i == DIV_START && !bus.annul_i) begin
                dvd_d   = op1_abs;
                dvs_d   = op2_abs;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                qneg_d  = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                rneg_d  = bus.signed_i & bus.opdata1_i[WIDTH-1];
                state_d = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: begin
                state_d = bus.annul_i ? DIV_FREE : DIV_END;
                rdy_d   = bus.annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
                hi_d    = '0;
                lo_d    = '0;
            end
            DIV_ON: if (bus.annul_i) begin
                state_d = DIV_FREE;
            end else begin
                rem_d = step_rem;
                quo_d = quo_fin;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DIV_END;
                    hi_d    = rneg_q ? -step_rem : step_rem;
                    lo_d    = qneg_q ? -quo_fin : quo_fin;
                    rdy_d   = DIV_RESULT_READY;
                end
            end
            DIV_END: if (bus.annul_i || bus.start_i == DIV_STOP) begin
                state_d = DIV_FREE;
                rdy_d   = DIV_RESULT_NOT_READY;
                hi_d    = '0;
                lo_d    = '0;
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rdy_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.ready_o    = rdy_q;
    assign bus.stallreq_o = bus.start_i & ~rdy_q;

endmodule

// File: tb/tb_mips_div.sv
// tb_mips_div: directed self-checking bench for the mips_div divider.
module tb_mips_div;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    mips_div_if #(.WIDTH(W)) bus ();

    mips_div #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       s;
        logic [W-1:0] a, b, q, r;
        int         lat;
    } vec_t;

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
    endtask

    // Edges counted include the sampling edge; -1 means the bound expired.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_i = 1'b0;
        bus.opdata1_i = '0; bus.opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.hi_o !== '0 || bus.lo_o !== '0 || bus.stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset: ready=%b hi=%h lo=%h stall=%b, want all 0", bus.ready_o, bus.hi_o, bus.lo_o, bus.stallreq_o);
        end
    endtask

    task automatic test_arith;
        vec_t v[8];
        int   n;
        v[0] = '{"divu_100_7",    1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        33};
        v[1] = '{"div_m100_7",    1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 33};
        v[2] = '{"div_100_m7",    1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        33};
        v[3] = '{"div_min_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        33};
        v[4] = '{"divu_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        33};
        v[5] = '{"divu_big_dvs",  1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1,        32'h7FFFFFFE, 33};
        v[6] = '{"divu_by_zero",  1'b0, 32'd5,        32'd0,        32'd0,        32'd0,        2};
        v[7] = '{"div_m7_by_zero",1'b1, 32'hFFFFFFF9, 32'd0,        32'd0,        32'd0,        2};
        for (int i = 0; i < 8; i++) begin
            issue(v[i].s, v[i].a, v[i].b);
            #1;
            checks++;
            if (bus.stallreq_o !== 1'b1) begin
                fails++;
                $display("FAIL %s stall_on_start: got %b want 1", v[i].name, bus.stallreq_o);
            end
            wait_ready(n);
            checks++;
            if (n !== v[i].lat) begin
                fails++;
                $display("FAIL %s latency: got %0d edges want %0d", v[i].name, n, v[i].lat);
            end
            checks++;
            if (bus.lo_o !== v[i].q || bus.hi_o !== v[i].r) begin
                fails++;
                $display("FAIL %s result: lo=%h hi=%h want lo=%h hi=%h", v[i].name, bus.lo_o, bus.hi_o, v[i].q, v[i].r);
            end
            checks++;
            if (bus.stallreq_o !== 1'b0) begin
                fails++;
                $display("FAIL %s stall_at_ready: got %b want 0", v[i].name, bus.stallreq_o);
            end
            bus.start_i = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (bus.ready_o !== 1'b0 || bus.lo_o !== '0 || bus.hi_o !== '0) begin
                fails++;
                $display("FAIL %s release: ready=%b lo=%h hi=%h want 0", v[i].name, bus.ready_o, bus.lo_o, bus.hi_o);
            end
        end
    endtask

    task automatic test_annul;
        int n;
        int highs = 0;
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o) highs++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (highs !== 0) begin
            fails++;
            $display("FAIL annul_no_ready: ready high %0d cycles want 0", highs);
        end
        issue(1'b0, 32'd9, 32'd2);
        wait_ready(n);
        checks++;
        if (n !== 33 || bus.lo_o !== 32'd4 || bus.hi_o !== 32'd1) begin
            fails++;
            $display("FAIL after_annul: edges=%0d lo=%h hi=%h want 33 4 1", n, bus.lo_o, bus.hi_o);
        end
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.lo_o !== '0) begin
            fails++;
            $display("FAIL annul_in_end: ready=%b lo=%h want 0 0", bus.ready_o, bus.lo_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_with_annul;
        int n;
        issue(1'b0, 32'd50, 32'd5);
        bus.annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        wait_ready(n);
        checks++;
        if (n !== 33 || bus.lo_o !== 32'd10 || bus.hi_o !== 32'd0) begin
            fails++;
            $display("FAIL start_with_annul: edges=%0d lo=%h hi=%h want 33 a 0", n, bus.lo_o, bus.hi_o);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold_end;
        int n;
        int bad = 0;
        issue(1'b0, 32'd1000, 32'd33);
        wait_ready(n);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b1 || bus.lo_o !== 32'd30 || bus.hi_o !== 32'd10 || bus.stallreq_o !== 1'b0) bad++;
        end
        checks++;
        if (n !== 33 || bad !== 0) begin
            fails++;
            $display("FAIL hold_end: edges=%0d unstable_cycles=%0d want 33 0 (lo=%h hi=%h)", n, bad, bus.lo_o, bus.hi_o);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.lo_o !== '0 || bus.hi_o !== '0) begin
            fails++;
            $display("FAIL hold_release: ready=%b lo=%h hi=%h want 0", bus.ready_o, bus.lo_o, bus.hi_o);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        issue(1'b0, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.hi_o !== '0 || bus.lo_o !== '0 || bus.stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b hi=%h lo=%h stall=%b want 0", bus.ready_o, bus.hi_o, bus.lo_o, bus.stallreq_o);
        end
        issue(1'b1, 32'hFFFFFFEC, 32'd3);
        wait_ready(n);
        checks++;
        if (n !== 33 || bus.lo_o !== 32'hFFFFFFFA || bus.hi_o !== 32'hFFFFFFFE) begin
            fails++;
            $display("FAIL after_reset: edges=%0d lo=%h hi=%h want 33 fffffffa fffffffe", n, bus.lo_o, bus.hi_o);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_arith;
        test_annul;
        test_start_with_annul;
        test_hold_end;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
